// File: rtl/delta_csr_bank_if.sv
// Host-side memory-mapped bus into the DeltaAcc CSR bank.
// The host (master) issues strobes; the bank (slave) returns registered read data.
interface delta_csr_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              ChipSelect;
    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic              ReadDataValid;

    modport master (
        output ChipSelect, Read, Write, Address, WriteData,
        input  ReadData, ReadDataValid
    );

    modport slave (
        input  ChipSelect, Read, Write, Address, WriteData,
        output ReadData, ReadDataValid
    );
endinterface

// File: rtl/delta_csr_bank.sv
// Control/status register bank for the DeltaAcc core: shadow config staged by the host,
// copied to the active set on START, plus start/ack/done handshake, sticky status and irq.
module delta_csr_bank #(
    parameter int DATA_W  = 32,
    parameter int NUM_CFG = 9,
    parameter int ADDR_W  = 4
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    delta_csr_bank_if.slave           bus,
    output logic                      o_irq,
    output logic                      o_start,
    input  logic                      i_ack,
    input  logic                      i_done,
    output logic                      o_busy,
    output logic [NUM_CFG*DATA_W-1:0] o_cfg_active
);

    localparam logic [ADDR_W-1:0] CTRL_ADDR   = '0;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(1);
    localparam int                SHADOW_BASE = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [DATA_W-1:0] r_shadow [NUM_CFG];
    logic [DATA_W-1:0] r_active [NUM_CFG];
    logic              r_irq_en;
    logic              r_done_sticky;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    logic              w_wr;
    logic              w_rd;
    logic              w_ctrl_we;
    logic              w_status_we;
    logic              w_unmapped;
    logic              w_start_cmd;
    logic              w_start_accept;
    logic              w_start_reject;
    logic              w_done_set;
    logic              w_err_set;
    logic              w_done_clr;
    logic              w_err_clr;
    logic [DATA_W-1:0] w_rd_mux;
    logic [NUM_CFG-1:0] w_shadow_we;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_wr        = bus.ChipSelect & bus.Write;
    assign w_rd        = bus.ChipSelect & bus.Read;
    assign w_ctrl_we   = w_wr & (bus.Address == CTRL_ADDR);
    assign w_status_we = w_wr & (bus.Address == STATUS_ADDR);
    assign w_unmapped  = ({1'b0, bus.Address} > (ADDR_W+1)'(NUM_CFG + 1));
    assign w_start_cmd = w_ctrl_we & bus.WriteData[0];

    assign w_done_clr  = w_status_we & bus.WriteData[1];
    assign w_err_clr   = w_status_we & bus.WriteData[2];
    assign w_err_set   = w_start_reject | (w_wr & w_unmapped);

    // ------------------------------------------------------------------
    // Layer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Layer FSM: next state and handshake events
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_start_accept = 1'b0;
        w_start_reject = 1'b0;
        w_done_set     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_cmd) begin
                    w_start_accept = 1'b1;
                    w_state_next   = S_REQ;
                end
            end
            S_REQ: begin
                w_start_reject = w_start_cmd;
                // A core that finishes in the very cycle it accepts skips RUN.
                if (i_ack) begin
                    if (i_done) begin
                        w_done_set   = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_start_reject = w_start_cmd;
                if (i_done) begin
                    w_done_set   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control and sticky status bits (set beats W1C clear)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_irq_en      <= 1'b0;
            r_done_sticky <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            if (w_ctrl_we) begin
                r_irq_en <= bus.WriteData[1];
            end

            if (w_done_set) begin
                r_done_sticky <= 1'b1;
            end else if (w_start_accept || w_done_clr) begin
                r_done_sticky <= 1'b0;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow and active configuration sets
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
            assign w_shadow_we[gi] = w_wr & (bus.Address == ADDR_W'(SHADOW_BASE + gi));

            // The copy samples r_shadow before this edge's update, so a
            // same-cycle shadow write lands only in the next layer.
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    r_shadow[gi] <= '0;
                    r_active[gi] <= '0;
                end else begin
                    if (w_shadow_we[gi]) begin
                        r_shadow[gi] <= bus.WriteData;
                    end
                    if (w_start_accept) begin
                        r_active[gi] <= r_shadow[gi];
                    end
                end
            end

            assign o_cfg_active[gi*DATA_W +: DATA_W] = r_active[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read path: pre-write register values, one cycle of latency
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = '0;
        if (bus.Address == CTRL_ADDR) begin
            w_rd_mux[1] = r_irq_en;
        end else if (bus.Address == STATUS_ADDR) begin
            w_rd_mux[0] = (r_state != S_IDLE);
            w_rd_mux[1] = r_done_sticky;
            w_rd_mux[2] = r_err;
        end else begin
            for (int k = 0; k < NUM_CFG; k++) begin
                if (bus.Address == ADDR_W'(SHADOW_BASE + k)) begin
                    w_rd_mux = r_shadow[k];
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ReadData      = r_rdata;
    assign bus.ReadDataValid = r_rvalid;
    assign o_start           = (r_state == S_REQ);
    assign o_busy            = (r_state != S_IDLE);
    assign o_irq             = r_done_sticky & r_irq_en;

endmodule

// File: tb/tb_delta_csr_bank.sv
// Directed plus randomized bench for delta_csr_bank against a cycle-level behavioural model.
module tb_delta_csr_bank;

    localparam int DATA_W  = 32;
    localparam int NUM_CFG = 9;
    localparam int ADDR_W  = 4;
    localparam int CFG_W   = NUM_CFG * DATA_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             ack;
    logic             done;
    logic             irq;
    logic             start;
    logic             busy;
    logic [CFG_W-1:0] cfg;

    delta_csr_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    delta_csr_bank #(.DATA_W(DATA_W), .NUM_CFG(NUM_CFG), .ADDR_W(ADDR_W)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .bus          (bus),
        .o_irq        (irq),
        .o_start      (start),
        .i_ack        (ack),
        .i_done       (done),
        .o_busy       (busy),
        .o_cfg_active (cfg)
    );

    always #5 clk = ~clk;

    // Reference model: layer phase is 0 = idle, 1 = waiting for ack, 2 = core running.
    logic [DATA_W-1:0] m_sh [NUM_CFG];
    logic [DATA_W-1:0] m_ac [NUM_CFG];
    logic              m_irq_en, m_done, m_err, m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    int                m_phase;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] exp);
        checks++;
        assert (act === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] m_read(input int a);
        logic [DATA_W-1:0] v = '0;
        if (a == 0) v[1] = m_irq_en;
        else if (a == 1) v = {29'd0, m_err, m_done, (m_phase != 0)};
        else if (a >= 2 && a <= NUM_CFG + 1) v = m_sh[a-2];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CFG; k++) begin
            m_sh[k] = '0;
            m_ac[k] = '0;
        end
        m_irq_en = 0; m_done = 0; m_err = 0; m_rvalid = 0; m_rdata = '0; m_phase = 0;
    endtask

    task automatic model_step(input logic cs, rd, wr, input int a, input logic [DATA_W-1:0] d,
                              input logic ak, dn);
        logic wrq   = cs & wr;
        logic rdq   = cs & rd;
        logic scmd  = wrq && a == 0 && d[0];
        logic dev   = 0;
        logic eev   = 0;
        int   nph   = m_phase;
        logic [DATA_W-1:0] rv = m_read(a);
        m_rvalid = rdq;
        if (rdq) m_rdata = rv;
        if (scmd) begin
            if (m_phase == 0) begin
                for (int k = 0; k < NUM_CFG; k++) m_ac[k] = m_sh[k];
                nph = 1;
            end else begin
                eev = 1;
            end
        end
        if (m_phase == 1 && ak) begin
            nph = dn ? 0 : 2;
            dev = dn;
        end
        if (m_phase == 2 && dn) begin
            nph = 0;
            dev = 1;
        end
        if (wrq && a > NUM_CFG + 1) eev = 1;
        if (wrq && a == 1) begin
            if (d[1]) m_done = 0;
            if (d[2]) m_err = 0;
        end
        if (scmd && m_phase == 0) m_done = 0;
        if (dev) m_done = 1;
        if (eev) m_err = 1;
        if (wrq && a == 0) m_irq_en = d[1];
        if (wrq && a >= 2 && a <= NUM_CFG + 1) m_sh[a-2] = d;
        m_phase = nph;
    endtask

    task automatic check_all();
        logic [CFG_W-1:0] exp_cfg;
        for (int k = 0; k < NUM_CFG; k++) exp_cfg[k*DATA_W +: DATA_W] = m_ac[k];
        chk("start", start, m_phase == 1);
        chk("busy", busy, m_phase != 0);
        chk("irq", irq, m_done & m_irq_en);
        chk("rvalid", bus.ReadDataValid, m_rvalid);
        chk("rdata", bus.ReadData, m_rdata);
        chk("cfg_active", cfg, exp_cfg);
    endtask

    task automatic cycle(input logic cs, rd, wr, input int a, input logic [DATA_W-1:0] d,
                         input logic ak, dn);
        bus.ChipSelect = cs;
        bus.Read       = rd;
        bus.Write      = wr;
        bus.Address    = ADDR_W'(a);
        bus.WriteData  = d;
        ack            = ak;
        done           = dn;
        model_step(cs, rd, wr, a, d, ak, dn);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        cycle(1, 0, 1, a, d, 0, 0);
    endtask

    task automatic rd(input int a);
        cycle(1, 1, 0, a, '0, 0, 0);
    endtask

    task automatic core(input logic ak, dn);
        cycle(0, 0, 0, 0, '0, ak, dn);
    endtask

    task automatic do_reset();
        rst = 1;
        bus.ChipSelect = 0; bus.Read = 0; bus.Write = 0; bus.Address = '0; bus.WriteData = '0;
        ack = 0; done = 0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 0;
        check_all();
    endtask

    initial begin
        do_reset();
        chk("reset_rdata", bus.ReadData, 32'h0);
        chk("reset_busy", busy, 1'b0);

        // T1: shadow write and readback, active set untouched
        wr(2, 32'hA5);
        rd(2);
        chk("t1_rvalid", bus.ReadDataValid, 1'b1);
        chk("t1_rdata", bus.ReadData, 32'hA5);
        chk("t1_active0", cfg[31:0], 32'h0);
        core(0, 0);
        chk("t1_rvalid_drop", bus.ReadDataValid, 1'b0);

        // T2: START with irq_en, handshake, done, W1C
        wr(0, 32'h3);
        chk("t2_start", start, 1'b1);
        chk("t2_active0", cfg[31:0], 32'hA5);
        core(1, 0);
        chk("t2_start_drop", start, 1'b0);
        chk("t2_busy", busy, 1'b1);
        core(0, 1);
        chk("t2_irq", irq, 1'b1);
        rd(1);
        chk("t2_status", bus.ReadData, 32'h2);
        wr(1, 32'h2);
        chk("t2_irq_clr", irq, 1'b0);

        // T3: START while running is rejected; staged shadow used later
        wr(0, 32'h1);
        core(1, 0);
        wr(2, 32'h11);
        wr(0, 32'h1);
        chk("t3_active_hold", cfg[31:0], 32'hA5);
        core(0, 1);
        rd(1);
        chk("t3_status", bus.ReadData, 32'h6);
        wr(1, 32'h6);
        wr(0, 32'h1);
        chk("t3_active_new", cfg[31:0], 32'h11);

        // T4: ack+done together in REQ; W1C racing a done event
        core(1, 1);
        chk("t4_idle", busy, 1'b0);
        rd(1);
        chk("t4_status", bus.ReadData, 32'h2);
        wr(0, 32'h1);
        core(1, 0);
        cycle(1, 0, 1, 1, 32'h2, 0, 1);
        rd(1);
        chk("t4_set_wins", bus.ReadData, 32'h2);

        // T5: unmapped access; read-before-write on same address
        wr(15, 32'hDEAD_BEEF);
        rd(1);
        chk("t5_err", bus.ReadData, 32'h6);
        rd(15);
        chk("t5_unmapped_rd", bus.ReadData, 32'h0);
        wr(3, 32'h1234_5678);
        cycle(1, 1, 1, 3, 32'h9ABC_DEF0, 0, 0);
        chk("t5_old_value", bus.ReadData, 32'h1234_5678);
        rd(3);
        chk("t5_new_value", bus.ReadData, 32'h9ABC_DEF0);

        // T6: reset in RUN, then a stray done
        wr(1, 32'h6);
        wr(0, 32'h3);
        core(1, 0);
        chk("t6_run", busy, 1'b1);
        do_reset();
        chk("t6_cfg_zero", cfg, '0);
        core(0, 1);
        chk("t6_stray_done", irq, 1'b0);
        rd(1);
        chk("t6_status", bus.ReadData, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 9) < 6), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 15), $urandom, ($urandom_range(0, 9) < 3),
                      ($urandom_range(0, 9) < 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
